// File: rtl/npc_ctrl.sv
// npc_ctrl - multi-cycle sequencer for the single-issue NPC core.
//
// Walks each instruction through FETCH -> DECODE -> EXEC -> (MEM) -> WB.
// It latches the fetched word into the instruction register and samples the
// decoder's class flags in DECODE. It owns the sticky halt state, entered on
// ebreak, on an illegal instruction, or when the fetch or memory bus fails to
// answer within TIMEOUT cycles.
//
// Ports
//   clk, rst          core clock, synchronous active-high reset
//   ifu_req           fetch request (high throughout FETCH)
//   ifu_rvalid/rdata  fetch response and the instruction word
//   ir                latched instruction, feeds the decoder
//   dec_*             decoder class flags, combinational from ir
//   lsu_req/wen       memory request (high throughout MEM), 1 = store
//   lsu_done          memory access complete
//   rf_wen, pc_wen    one-cycle writeback strobes
//   halt, halt_code   sticky stop flag and its cause (1 ebreak, 2 illegal, 3 timeout)
//   state             current sequencer state (debug)
//   instret           retired instruction count, wraps
module npc_ctrl #(
  parameter int ISA_WIDTH = 32,
  parameter int TIMEOUT   = 16,
  parameter int CNT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 ifu_req,
  input  logic                 ifu_rvalid,
  input  logic [ISA_WIDTH-1:0] ifu_rdata,
  output logic [ISA_WIDTH-1:0] ir,
  input  logic                 dec_reg_wr,
  input  logic                 dec_mem_rd,
  input  logic                 dec_mem_wr,
  input  logic                 dec_ebreak,
  input  logic                 dec_illegal,
  output logic                 lsu_req,
  output logic                 lsu_wen,
  input  logic                 lsu_done,
  output logic                 rf_wen,
  output logic                 pc_wen,
  output logic                 halt,
  output logic [1:0]           halt_code,
  output logic [2:0]           state,
  output logic [CNT_WIDTH-1:0] instret
);

  localparam int WAIT_W = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [1:0] CODE_EBREAK  = 2'd1;
  localparam logic [1:0] CODE_ILLEGAL = 2'd2;
  localparam logic [1:0] CODE_TIMEOUT = 2'd3;

  state_t                 r_state;
  logic [ISA_WIDTH-1:0]   r_ir;
  logic [CNT_WIDTH-1:0]   r_instret;
  logic [1:0]             r_halt_code;
  logic [WAIT_W-1:0]      r_wait;
  logic                   r_reg_wr;
  logic                   r_mem_rd;
  logic                   r_mem_wr;
  logic                   w_wait_last;

  // Last permitted wait cycle: no response now means a bus timeout.
  assign w_wait_last = (r_wait == WAIT_W'(TIMEOUT - 1));

  // Sequencer: state, instruction register, latched class flags, wait counter,
  // retire counter and halt cause.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ir        <= '0;
      r_instret   <= '0;
      r_halt_code <= 2'd0;
      r_wait      <= '0;
      r_reg_wr    <= 1'b0;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_wait  <= '0;
          r_state <= S_FETCH;
        end
        S_FETCH: begin
          // A response on the last wait cycle still counts as in time.
          if (ifu_rvalid) begin
            r_ir    <= ifu_rdata;
            r_state <= S_DECODE;
          end else if (w_wait_last) begin
            r_halt_code <= CODE_TIMEOUT;
            r_state     <= S_HALT;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        S_DECODE: begin
          r_reg_wr <= dec_reg_wr;
          r_mem_rd <= dec_mem_rd;
          r_mem_wr <= dec_mem_wr;
          // Illegal takes precedence; ebreak retires before stopping.
          if (dec_illegal) begin
            r_halt_code <= CODE_ILLEGAL;
            r_state     <= S_HALT;
          end else if (dec_ebreak) begin
            r_instret   <= r_instret + CNT_WIDTH'(1);
            r_halt_code <= CODE_EBREAK;
            r_state     <= S_HALT;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          // Load and store at once is not a real instruction class.
          if (r_mem_rd && r_mem_wr) begin
            r_halt_code <= CODE_ILLEGAL;
            r_state     <= S_HALT;
          end else if (r_mem_rd || r_mem_wr) begin
            r_wait  <= '0;
            r_state <= S_MEM;
          end else begin
            r_state <= S_WB;
          end
        end
        S_MEM: begin
          if (lsu_done) begin
            r_state <= S_WB;
          end else if (w_wait_last) begin
            r_halt_code <= CODE_TIMEOUT;
            r_state     <= S_HALT;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        S_WB: begin
          r_instret <= r_instret + CNT_WIDTH'(1);
          r_wait    <= '0;
          r_state   <= S_FETCH;
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs decode registered state and latched flags only; no bus input
  // reaches an output combinationally.
  assign ifu_req   = (r_state == S_FETCH);
  assign lsu_req   = (r_state == S_MEM);
  assign lsu_wen   = (r_state == S_MEM) && r_mem_wr;
  assign rf_wen    = (r_state == S_WB) && r_reg_wr && !r_mem_wr;
  assign pc_wen    = (r_state == S_WB);
  assign halt      = (r_state == S_HALT);
  assign halt_code = r_halt_code;
  assign state     = r_state;
  assign ir        = r_ir;
  assign instret   = r_instret;

endmodule

// File: tb/tb_npc_ctrl.sv
module tb_npc_ctrl;

  localparam int TO = 16;
  localparam int CW = 4;   // narrow counter so that wrap-around is exercised

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ifu_req;
  logic          ifu_rvalid = 1'b0;
  logic [31:0]   ifu_rdata = 32'd0;
  logic [31:0]   ir;
  logic          dec_reg_wr = 1'b0;
  logic          dec_mem_rd = 1'b0;
  logic          dec_mem_wr = 1'b0;
  logic          dec_ebreak = 1'b0;
  logic          dec_illegal = 1'b0;
  logic          lsu_req;
  logic          lsu_wen;
  logic          lsu_done = 1'b0;
  logic          rf_wen;
  logic          pc_wen;
  logic          halt;
  logic [1:0]    halt_code;
  logic [2:0]    state;
  logic [CW-1:0] instret;

  int ntests = 0;
  int nfail  = 0;

  // Reference model: architectural results only.
  logic [31:0]   exp_ir;
  logic [CW-1:0] exp_instret;
  logic [1:0]    exp_code;

  npc_ctrl #(.ISA_WIDTH(32), .TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .ifu_req(ifu_req), .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .ir(ir),
    .dec_reg_wr(dec_reg_wr), .dec_mem_rd(dec_mem_rd), .dec_mem_wr(dec_mem_wr),
    .dec_ebreak(dec_ebreak), .dec_illegal(dec_illegal),
    .lsu_req(lsu_req), .lsu_wen(lsu_wen), .lsu_done(lsu_done),
    .rf_wen(rf_wen), .pc_wen(pc_wen), .halt(halt), .halt_code(halt_code),
    .state(state), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    ntests++;
    assert (obs === exp_v) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    exp_ir      = 32'd0;
    exp_instret = '0;
    exp_code    = 2'd0;
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Checks one cycle's outputs (at the negedge), then drives inputs for the
  // next rising edge and advances to the following negedge.
  task automatic step(input logic [2:0] st, input logic ireq, lreq, lwen, rfw, pcw,
                      input logic rv, ld, r, input logic [31:0] word);
    chk("state", 64'(state), 64'(st));
    chk("ifu_req", 64'(ifu_req), 64'(ireq));
    chk("lsu_req", 64'(lsu_req), 64'(lreq));
    if (lreq) chk("lsu_wen", 64'(lsu_wen), 64'(lwen));
    chk("rf_wen", 64'(rf_wen), 64'(rfw));
    chk("pc_wen", 64'(pc_wen), 64'(pcw));
    chk("halt", 64'(halt), 64'(st == 3'd6));
    chk("halt_code", 64'(halt_code), 64'(exp_code));
    chk("ir", 64'(ir), 64'(exp_ir));
    chk("instret", 64'(instret), 64'(exp_instret));
    ifu_rvalid = rv;
    ifu_rdata  = rv ? word : $urandom();
    lsu_done   = ld;
    rst        = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  // One instruction, phase by phase. fw/lw: index of the fetch/LSU cycle that
  // answers (>= TO means no answer). rst_at: MEM cycle at which reset hits.
  task automatic do_instr(input logic [31:0] word, input logic rw, mrd, mwr, eb, il,
                          input int fw, input int lw, input int rst_at);
    int n;
    dec_reg_wr = rw; dec_mem_rd = mrd; dec_mem_wr = mwr;
    dec_ebreak = eb; dec_illegal = il;
    n = (fw < TO) ? fw + 1 : TO;
    for (int i = 0; i < n; i++)
      step(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, logic'(i == fw), rnd_bit(), 1'b0, word);
    if (fw >= TO) begin exp_code = 2'd3; return; end
    exp_ir = word;
    step(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rnd_bit(), 1'b0, word);
    if (il) begin exp_code = 2'd2; return; end
    if (eb) begin exp_instret = exp_instret + CW'(1); exp_code = 2'd1; return; end
    step(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rnd_bit(), 1'b0, word);
    if (mrd && mwr) begin exp_code = 2'd2; return; end
    if (mrd || mwr) begin
      n = (lw < TO) ? lw + 1 : TO;
      for (int i = 0; i < n; i++) begin
        step(3'd4, 1'b0, 1'b1, mwr, 1'b0, 1'b0, 1'b0, logic'(i == lw), logic'(i == rst_at), word);
        if (i == rst_at) begin
          model_reset();
          step(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rnd_bit(), 1'b0, word);
          return;
        end
      end
      if (lw >= TO) begin exp_code = 2'd3; return; end
    end
    step(3'd5, 1'b0, 1'b0, 1'b0, rw & ~mwr, 1'b1, 1'b0, rnd_bit(), 1'b0, word);
    exp_instret = exp_instret + CW'(1);
  endtask

  // Stay in HALT for n cycles (reset raised on the last), then check IDLE.
  task automatic halt_then_reset(input int n);
    for (int i = 0; i < n; i++)
      step(3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rnd_bit(), rnd_bit(), logic'(i == n - 1), 32'd0);
    model_reset();
    step(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rnd_bit(), 1'b0, 32'd0);
  endtask

  initial begin
    int kind;
    logic rw;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    step(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

    // addi, lb (LSU answers on 4th MEM cycle), sb, store with reg_wr masked
    do_instr(32'h00500093, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, -1);
    do_instr(32'h00008083, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 3, -1);
    do_instr(32'h00108023, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, -1);
    do_instr(32'h00208123, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1, 2, -1);

    // Random mix of ALU / load / store with random bus latencies
    for (int k = 0; k < 20; k++) begin
      kind = int'($urandom_range(0, 2));
      rw   = rnd_bit();
      do_instr($urandom(), rw, logic'(kind == 1), logic'(kind == 2), 1'b0, 1'b0,
               int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), -1);
    end

    // Fetch timeout boundary: answer on 16th cycle is in time, none halts
    do_instr(32'h00100113, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, TO - 1, 0, -1);
    do_instr(32'h00100113, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, TO, 0, -1);
    halt_then_reset(3);

    // Memory timeout boundary
    do_instr(32'h00008083, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, TO - 1, -1);
    do_instr(32'h00008083, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, TO, -1);
    halt_then_reset(3);

    // ebreak retires and halts; stays halted for 20 more cycles
    do_instr(32'h00100073, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, -1);
    halt_then_reset(21);

    // Illegal alone, illegal together with ebreak, load+store flags together
    do_instr(32'hffffffff, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2, 0, -1);
    halt_then_reset(2);
    do_instr(32'h00500093, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, -1);
    do_instr(32'h00100073, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, -1);
    halt_then_reset(2);
    do_instr(32'h12345678, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, -1);
    halt_then_reset(2);

    // Reset during MEM wait, then normal restart
    do_instr(32'h00500093, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, -1);
    do_instr(32'h00008083, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 10, 2);
    do_instr(32'h00500093, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, -1);
    do_instr(32'h00008083, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1, -1);
    step(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
